// File: rtl/traffic_gen_pe.sv
// traffic_gen_pe: synthetic NoC traffic source and latency sink.
// Injects timestamped flits on one router port, gathers ejection stats.
module traffic_gen_pe #(
  parameter int XCORD = 0,
  parameter int YCORD = 0,
  parameter int X = 4,
  parameter int Y = 4,
  parameter int DEST_X = 2,
  parameter int DEST_Y = 2,
  parameter int SOURCE_X = 8,
  parameter int SOURCE_Y = 8,
  parameter int DATA_WIDTH = 240,
  parameter int TOTAL_WIDTH =
    DEST_X + DEST_Y + SOURCE_X + SOURCE_Y + DATA_WIDTH,
  parameter int NUM_PKTS = 3,
  parameter int RATE = 1,
  parameter int BURST_LEN = 1,
  parameter int PATTERN = 4,
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   enable_send,
  output logic [TOTAL_WIDTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  input  logic [TOTAL_WIDTH-1:0] i_data,
  input  logic                   i_valid,
  output logic                   done,
  output logic [31:0]            tx_count,
  output logic [31:0]            rx_count,
  output logic [31:0]            lat_min,
  output logic [31:0]            lat_max,
  output logic [47:0]            lat_sum
);

  localparam int HDR =
    DEST_X + DEST_Y + SOURCE_X + SOURCE_Y;
  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] MIX =
    SEED ^ 32'(YCORD * X + XCORD + 1);
  localparam logic [31:0] LFSR_RST =
    (MIX == 32'h0) ? 32'h1 : MIX;
  localparam int RIGHT_X = (XCORD + 1) % X;
  localparam int TOP_Y = (YCORD + 1) % Y;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SEND,
    DONE
  } state_t;

  state_t state;

  logic [31:0] cyc;
  logic [31:0] phase;
  logic [31:0] phase_nxt;
  logic [31:0] burst_cnt;
  logic [31:0] lfsr;
  logic [31:0] lfsr_nxt;
  logic [DEST_X-1:0] dx;
  logic [DEST_Y-1:0] dy;
  logic [15:0] seq_gen;
  logic [DATA_WIDTH-1:0] data;
  logic [TOTAL_WIDTH-1:0] flit;
  logic [31:0] lat;
  logic [48:0] sum_ext;
  logic unused_bits;

  // Galois step and tick-phase wrap
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
    phase_nxt = (phase == 32'(RATE - 1)) ? 32'h0 : phase + 32'h1;
  end

  // Destination of the packet being generated this cycle
  always_comb begin
    dx = DEST_X'(XCORD);
    dy = DEST_Y'(YCORD);
    unique case (1'b1)
      (PATTERN == 0): begin
        dx = DEST_X'({16'h0, lfsr[15:0]} % 32'(X));
        dy = DEST_Y'({16'h0, lfsr[31:16]} % 32'(Y));
      end
      (PATTERN == 2): dx = DEST_X'(RIGHT_X);
      (PATTERN == 3): dy = DEST_Y'(TOP_Y);
      (PATTERN == 4): begin
        if (lfsr[0]) dy = DEST_Y'(TOP_Y);
        else dx = DEST_X'(RIGHT_X);
      end
      (PATTERN == 5): begin
        dx = DEST_X'(YCORD);
        dy = DEST_Y'(XCORD);
      end
      default: ;
    endcase
  end

  // Flit assembly; timestamp is the cycle in which it becomes visible
  always_comb begin
    seq_gen = tx_count[15:0] + {15'h0, state == SEND};
    data = '0;
    data[31:0] = cyc + 32'h1;
    data[47:32] = seq_gen;
    flit = {data, SOURCE_Y'(YCORD), SOURCE_X'(XCORD), dy, dx};
  end

  // Free-running cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else cyc <= cyc + 32'h1;
  end

  // Injection FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      burst_cnt <= '0;
      lfsr <= LFSR_RST;
      o_valid <= 1'b0;
      o_data <= '0;
      done <= 1'b0;
      tx_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            phase <= '0;
          end
        end
        ARM: begin
          phase <= phase_nxt;
          if (!start) begin
            state <= IDLE;
          end else if (phase == 32'h0 && enable_send) begin
            o_data <= flit;
            lfsr <= lfsr_nxt;
            burst_cnt <= '0;
            o_valid <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          phase <= phase_nxt;
          if (i_ready) begin
            tx_count <= tx_count + 32'h1;
            if (tx_count + 32'h1 == 32'(NUM_PKTS)) begin
              state <= DONE;
              o_valid <= 1'b0;
              done <= 1'b1;
            end else if (!start) begin
              state <= IDLE;
              o_valid <= 1'b0;
            end else if (burst_cnt + 32'h1 < 32'(BURST_LEN)) begin
              o_data <= flit;
              lfsr <= lfsr_nxt;
              burst_cnt <= burst_cnt + 32'h1;
            end else begin
              state <= ARM;
              o_valid <= 1'b0;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign lat = cyc - i_data[HDR +: 32];
  assign sum_ext = {1'b0, lat_sum} + {17'h0, lat};
  assign unused_bits = ^i_data;

  // Ejection-side latency statistics, active in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_count <= '0;
      lat_min <= 32'hFFFF_FFFF;
      lat_max <= '0;
      lat_sum <= '0;
    end else if (i_valid) begin
      rx_count <= rx_count + 32'h1;
      lat_sum <= sum_ext[48] ? '1 : sum_ext[47:0];
      if (lat < lat_min) lat_min <= lat;
      if (lat > lat_max) lat_max <= lat;
    end
  end

endmodule

// File: doc/traffic_gen_pe.md
# traffic_gen_pe

Parametrised synthetic-traffic processing element for NoC testbenches and on-chip self-test. It attaches to one router local port. It injects NUM_PKTS packets in a selectable spatial pattern at a programmable rate with bursts, and holds each packet under a true valid/ready handshake until the router accepts it. It timestamps every packet and keeps ejection-side latency statistics (count, min, max, sum), so the harness reads results from ports rather than from log files.

## Interface
Parameters:
- XCORD, 0, this PE's x coordinate
- YCORD, 0, this PE's y coordinate
- X, 4, mesh width
- Y, 4, mesh height
- DEST_X, 2, width of dest-x field
- DEST_Y, 2, width of dest-y field
- SOURCE_X, 8, width of src-x field
- SOURCE_Y, 8, width of src-y field
- DATA_WIDTH, 240, payload width; must be ≥48
- TOTAL_WIDTH, DEST_X+DEST_Y+SOURCE_X+SOURCE_Y+DATA_WIDTH, flit width
- NUM_PKTS, 3, packets to inject; ≥1
- RATE, 1, injection-tick period in cycles; ≥1
- BURST_LEN, 1, packets sent back-to-back per tick; ≥1
- PATTERN, 4, traffic pattern: 0 RANDOM, 1 SELF, 2 RIGHT, 3 TOP, 4 MIXED, 5 TRANSPOSE (requires X==Y)
- SEED, 32'h1, LFSR seed modifier

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  level; injection is enabled while high
- enable_send  in  1  gates the start of new bursts only
- o_data  out  TOTAL_WIDTH  injected flit
- o_valid  out  1  flit valid
- i_ready  in  1  router accepts the flit
- i_data  in  TOTAL_WIDTH  ejected flit
- i_valid  in  1  ejected flit valid; always consumed, no backpressure
- done  out  1  all NUM_PKTS packets accepted
- tx_count  out  32  packets accepted by the router
- rx_count  out  32  packets received
- lat_min  out  32  minimum latency
- lat_max  out  32  maximum latency
- lat_sum  out  48  sum of latencies

## Operation
- Flit layout, LSB first: dest_x, dest_y, src_x=XCORD, src_y=YCORD, then data. data[31:0] holds the injection timestamp. data[47:32] holds the tx sequence number, 0-based. The remaining data bits are 0.
- cycle: a 32-bit free-running counter, cleared by rst, that wraps modulo 2^32.
- LFSR: 32-bit Galois, taps 32'h80200003.
  - Reset value is SEED ^ (YCORD*X+XCORD+1). If that value is 0, the reset value is 32'h1.
  - The LFSR advances exactly once per generated packet.
- Destination selection, computed when a packet is generated:
  - RANDOM: dest_x = lfsr[15:0] % X, dest_y = lfsr[31:16] % Y.
  - SELF: own coordinates.
  - RIGHT: ((XCORD+1) % X, YCORD).
  - TOP: (XCORD, (YCORD+1) % Y).
  - MIXED: lfsr[0] = 0 selects RIGHT; lfsr[0] = 1 selects TOP.
  - TRANSPOSE: (YCORD, XCORD).
- FSM states: IDLE, ARM, SEND, DONE.
  - IDLE: o_valid=0. When start=1, go to ARM and clear the phase counter.
  - ARM: the phase counter counts 0..RATE-1 and a tick occurs at phase 0. On a tick with enable_send=1:
    - generate a packet,
    - set burst_cnt=0,
    - go to SEND.
    A tick with enable_send=0 is skipped; tick credits do not accumulate.
  - SEND: o_valid=1 and o_data is stable until i_ready=1. On acceptance, tx_count increments, then:
    - if tx_count reaches NUM_PKTS, go to DONE;
    - else if burst_cnt+1 < BURST_LEN, generate the next packet in the same cycle, stay in SEND, and keep o_valid=1 with no bubble;
    - otherwise go to ARM.
  - DONE: o_valid=0 and done=1. The FSM stays in DONE until rst.
- start falling in ARM returns the FSM to IDLE. start falling in SEND does not drop o_valid; the FSM goes to IDLE after the current flit is accepted. enable_send has no effect in SEND.
- Receive path, on each i_valid:
  - lat = cycle − i_data timestamp, modulo 2^32;
  - rx_count increments;
  - lat_sum += lat, saturating at 2^48−1;
  - lat_min and lat_max are updated.
  The receive path operates in every FSM state, including IDLE and DONE.

## Timing
- Reset values:
  - o_valid=0, o_data=0, done=0;
  - tx_count=0, rx_count=0;
  - lat_min=32'hFFFFFFFF, lat_max=0, lat_sum=0;
  - cycle=0, FSM in IDLE.
- rst assertion takes effect immediately. An in-flight o_valid drops without waiting for i_ready.
- Injection timing:
  - The first o_valid rises at the earliest 2 cycles after start is sampled high: IDLE→ARM, then tick at phase 0.
  - The timestamp equals cycle in the cycle o_valid first rises for that packet.
- i_ready is sampled at the posedge where o_valid=1. That edge counts as acceptance.
- Receive-path outputs (all statistics) update on the posedge that samples i_valid, and are visible in the next cycle.
- done rises the cycle after the final acceptance, together with o_valid falling.
- Boundary cases:
  - With RATE=1 and BURST_LEN=1, a 1-cycle ARM gap separates packets.
  - If BURST_LEN > the packets remaining, the FSM terminates in DONE early.
  - A cycle wrap between injection and ejection still yields the correct latency through modulo subtraction.

## Test plan
- PATTERN=1, NUM_PKTS=3, i_ready tied 1, loop o_data→i_data with 1-cycle delay -> tx_count=3, rx_count=3, lat_min=lat_max=1, lat_sum=3, done=1.
- PATTERN=2, XCORD=3, X=4, i_ready=0 for 10 cycles then 1 -> o_data stable over all 10 held cycles; dest=(0,YCORD); timestamp unchanged.
- RATE=4, BURST_LEN=2, NUM_PKTS=5, i_ready=1 -> accepts occur in pairs, ticks are 4 cycles apart, the last burst holds 1 packet, then done.
- PATTERN=0, NUM_PKTS=1000, X=Y=4 -> every dest_x and dest_y is <4, all 16 destinations are hit, and the sequence is identical across two runs with the same SEED.
- Inject i_data with timestamp 32'hFFFFFFFE when cycle=1 -> lat=3.
- rst asserted while o_valid=1 mid-burst -> o_valid=0 without a clock edge, all counters reset, and re-injection restarts at sequence number 0.
